// File: rtl/conv_mem_pkg.sv
// Shared constants for the CONV responder: bank codes, flat layer-store map,
// FSM state encoding, sticky error bit positions and the address decoder.
package conv_mem_pkg;

    localparam int LAW         = 14;      // flat layer-store address width
    localparam int IMG_DEPTH   = 4096;
    localparam int LAYER_DEPTH = 12288;

    localparam logic [2:0] SEL_IMG  = 3'b000;
    localparam logic [2:0] SEL_L0K0 = 3'b001;
    localparam logic [2:0] SEL_L0K1 = 3'b010;
    localparam logic [2:0] SEL_L1K0 = 3'b011;
    localparam logic [2:0] SEL_L1K1 = 3'b100;
    localparam logic [2:0] SEL_L2   = 3'b101;

    localparam logic [LAW-1:0] BASE_L0K0 = 14'd0;
    localparam logic [LAW-1:0] BASE_L0K1 = 14'd4096;
    localparam logic [LAW-1:0] BASE_L1K0 = 14'd8192;
    localparam logic [LAW-1:0] BASE_L1K1 = 14'd9216;
    localparam logic [LAW-1:0] BASE_L2   = 14'd10240;
    localparam logic [LAW-1:0] DEPTH_L0  = 14'd4096;
    localparam logic [LAW-1:0] DEPTH_L1  = 14'd1024;
    localparam logic [LAW-1:0] DEPTH_L2  = 14'd2048;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam int ERR_SEL  = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_HOST = 2;
    localparam int ERR_TMO  = 3;

    typedef struct packed {
        logic           sel_ok;    // code names a layer bank
        logic           in_range;  // address below that bank's depth
        logic [LAW-1:0] flat;      // base + address in the flat store
    } map_t;

    // Decode a bank code and bank-relative address into the flat layer store.
    // The image code (000) is not a layer bank and reports sel_ok=0.
    function automatic map_t map_layer(input logic [2:0] sel, input logic [LAW-1:0] addr);
        map_t           m;
        logic [LAW-1:0] base;
        logic [LAW-1:0] depth;
        base  = '0;
        depth = '0;
        case (sel)
            SEL_L0K0: begin base = BASE_L0K0; depth = DEPTH_L0; end
            SEL_L0K1: begin base = BASE_L0K1; depth = DEPTH_L0; end
            SEL_L1K0: begin base = BASE_L1K0; depth = DEPTH_L1; end
            SEL_L1K1: begin base = BASE_L1K1; depth = DEPTH_L1; end
            SEL_L2:   begin base = BASE_L2;   depth = DEPTH_L2; end
            default:  ;
        endcase
        m.sel_ok   = (depth != '0);
        m.in_range = (addr < depth);
        m.flat     = base + addr;
        return m;
    endfunction

    // One-hot layer index of a bank code: [0] L0, [1] L1, [2] L2.
    function automatic logic [2:0] layer_bit(input logic [2:0] sel);
        case (sel)
            SEL_L0K0, SEL_L0K1: return 3'b001;
            SEL_L1K0, SEL_L1K1: return 3'b010;
            SEL_L2:             return 3'b100;
            default:            return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Single-clock 1R1W synchronous RAM. A read that hits the address being
// written in the same cycle returns the new data. The read register only
// updates on re, so it holds its last word otherwise.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port plus write-first registered read port.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/conv_mem_resp.sv
// Responder side of the CONV interface: start handshake FSM, image and layer
// stores, CONV/host port arbitration by FSM state, sticky flags.
module conv_mem_resp
    import conv_mem_pkg::*;
#(
    parameter int DW          = 20,
    parameter int AW          = 12,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    input  logic [2:0]    csel,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    h_sel,
    input  logic          h_we,
    input  logic          h_re,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    output logic          done,
    output logic [2:0]    layer_wr,
    output logic [3:0]    err
);

    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    state_t        state;
    logic [TW-1:0] tmo;

    logic run, host_ok, arm_entry, tmo_hit;
    assign run       = (state == RUN);
    assign host_ok   = (state == IDLE) || (state == DONE);
    assign arm_entry = (state == IDLE) && start;
    assign tmo_hit   = (state == ARM) && !busy && (tmo == TW'(ARM_TIMEOUT - 1));

    map_t wmap, rmap, hmap;
    assign wmap = map_layer(csel,  LAW'(caddr_wr));
    assign rmap = map_layer(csel,  LAW'(caddr_rd));
    assign hmap = map_layer(h_sel, LAW'(h_addr));

    logic conv_wr_ok, conv_rd_ok, h_img, h_lay_ok;
    logic host_wr_lay, host_rd_lay, host_wr_img, host_rd_img;
    assign conv_wr_ok  = run && cwr && wmap.sel_ok && wmap.in_range;
    assign conv_rd_ok  = run && crd && rmap.sel_ok && rmap.in_range;
    assign h_img       = (h_sel == SEL_IMG);
    assign h_lay_ok    = hmap.sel_ok && hmap.in_range;
    assign host_wr_lay = host_ok && h_we && h_lay_ok;
    assign host_rd_lay = host_ok && h_re && h_lay_ok;
    assign host_wr_img = host_ok && h_we && h_img;
    assign host_rd_img = host_ok && h_re && h_img;

    // CONV owns the RAM ports only in RUN; host owns them otherwise.
    logic [DW-1:0] img_q, lay_q;

    conv_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW)) u_img (
        .clk   (clk),
        .we    (host_wr_img),
        .waddr (h_addr),
        .wdata (h_wdata),
        .re    (run || host_rd_img),
        .raddr (run ? iaddr : h_addr),
        .rdata (img_q)
    );

    conv_bank_ram #(.DEPTH(LAYER_DEPTH), .DW(DW)) u_lay (
        .clk   (clk),
        .we    (conv_wr_ok || host_wr_lay),
        .waddr (run ? wmap.flat : hmap.flat),
        .wdata (run ? cdata_wr : h_wdata),
        .re    (conv_rd_ok || host_rd_lay),
        .raddr (run ? rmap.flat : hmap.flat),
        .rdata (lay_q)
    );

    // Newly raised error conditions this cycle.
    logic [3:0] err_set;
    always_comb begin
        err_set           = '0;
        err_set[ERR_SEL]  = (run && (cwr || crd) && !wmap.sel_ok)
                         || (host_ok && (h_we || h_re) && !h_img && !hmap.sel_ok);
        err_set[ERR_ADDR] = (run && ((cwr && wmap.sel_ok && !wmap.in_range)
                                  || (crd && rmap.sel_ok && !rmap.in_range)))
                         || (host_ok && (h_we || h_re) && hmap.sel_ok && !hmap.in_range);
        err_set[ERR_HOST] = (state == ARM || run) && (h_we || h_re);
        err_set[ERR_TMO]  = tmo_hit;
    end

    // Start handshake FSM with registered ready/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ready <= 1'b0;
            done  <= 1'b0;
            tmo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= ARM;
                    ready <= 1'b1;
                    tmo   <= '0;
                end
                ARM: if (busy) begin
                    state <= RUN;
                    ready <= 1'b0;
                end else if (tmo_hit) begin
                    state <= IDLE;
                    ready <= 1'b0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                RUN: if (!busy) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags, wiped when a new run is armed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= '0;
            layer_wr <= '0;
        end else begin
            err      <= (arm_entry ? 4'b0 : err) | err_set;
            layer_wr <= (arm_entry ? 3'b0 : layer_wr) | (conv_wr_ok ? layer_bit(csel) : 3'b0);
        end
    end

    // Read-return tracking: which source feeds each output port next cycle.
    logic          img_vld, crd_q, crd_zero_q, hrd_q, hrd_img_q, hrd_zero_q;
    logic [DW-1:0] cd_hold, h_hold;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_vld    <= 1'b0;
            crd_q      <= 1'b0;
            crd_zero_q <= 1'b0;
            hrd_q      <= 1'b0;
            hrd_img_q  <= 1'b0;
            hrd_zero_q <= 1'b0;
            cd_hold    <= '0;
            h_hold     <= '0;
        end else begin
            img_vld    <= run;
            crd_q      <= run && crd;
            crd_zero_q <= !conv_rd_ok;
            hrd_q      <= host_ok && h_re;
            hrd_img_q  <= h_img;
            hrd_zero_q <= !(h_img || h_lay_ok);
            cd_hold    <= cdata_rd;
            h_hold     <= h_rdata;
        end
    end

    assign idata    = img_vld ? img_q : '0;
    assign cdata_rd = crd_q ? (crd_zero_q ? '0 : lay_q) : cd_hold;
    assign h_rdata  = hrd_q ? (hrd_zero_q ? '0 : (hrd_img_q ? img_q : lay_q)) : h_hold;

endmodule

// File: tb/tb_conv_mem_resp.sv
// Randomized bench for conv_mem_resp against a bank-table memory model.
module tb_conv_mem_resp;

    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset, start, busy, cwr, crd, h_we, h_re;
    logic [AW-1:0] iaddr, caddr_wr, caddr_rd, h_addr;
    logic [DW-1:0] cdata_wr, h_wdata;
    logic [2:0]    csel, h_sel;
    logic          ready, done;
    logic [DW-1:0] idata, cdata_rd, h_rdata;
    logic [2:0]    layer_wr;
    logic [3:0]    err;

    conv_mem_resp #(.DW(DW), .AW(AW), .ARM_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .csel(csel),
        .cdata_rd(cdata_rd), .h_sel(h_sel), .h_we(h_we), .h_re(h_re),
        .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .done(done),
        .layer_wr(layer_wr), .err(err)
    );

    always #5 clk = ~clk;

    // Bank table indexed by code; code 0 is the separate image store.
    int base_t[8]  = '{0, 0, 4096, 8192, 9216, 10240, 0, 0};
    int depth_t[8] = '{4096, 4096, 4096, 1024, 1024, 2048, 0, 0};

    logic [DW-1:0] img_m[int];
    logic [DW-1:0] lay_m[int];
    logic [DW-1:0] cd_exp, hr_exp;
    logic [2:0]    lw_exp;
    logic [3:0]    err_exp;
    int            vecs, errs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mread(input int sel, input int addr);
        if (sel == 0) return img_m[addr];
        if (depth_t[sel] > 0 && addr < depth_t[sel]) return lay_m[base_t[sel] + addr];
        return '0;
    endfunction

    function automatic logic [2:0] lbit(input int sel);
        if (sel == 1 || sel == 2) return 3'b001;
        if (sel == 3 || sel == 4) return 3'b010;
        if (sel == 5) return 3'b100;
        return 3'b000;
    endfunction

    // Address drawn from the preloaded pool plus each bank's edge cases.
    function automatic int pick(input int sel);
        int k;
        k = $urandom_range(0, 9);
        if (k < 8) return k;
        if (k == 8) return (depth_t[sel] - 1) & 'hFFF;
        return depth_t[sel] & 'hFFF;
    endfunction

    task automatic host_wr(input int sel, input int addr, input logic [DW-1:0] d);
        h_sel = 3'(sel); h_addr = 12'(addr); h_wdata = d; h_we = 1'b1;
        tick();
        h_we = 1'b0;
        if (sel == 0) img_m[addr] = d;
        else lay_m[base_t[sel] + addr] = d;
    endtask

    task automatic host_rd(input string tag, input int sel, input int addr);
        h_sel = 3'(sel); h_addr = 12'(addr); h_re = 1'b1;
        tick();
        h_re = 1'b0;
        hr_exp = mread(sel, addr);
        chk(tag, h_rdata, hr_exp);
    endtask

    // One CONV cycle; live says whether the responder is in RUN.
    task automatic conv_cyc(input bit live, input bit w, input bit r, input int sel,
                            input int aw, input logic [DW-1:0] d, input int ar, input int ia);
        bit sv;
        cwr = w; crd = r; csel = 3'(sel); caddr_wr = 12'(aw); caddr_rd = 12'(ar);
        cdata_wr = d; iaddr = 12'(ia);
        tick();
        cwr = 1'b0; crd = 1'b0;
        if (live) begin
            sv = depth_t[sel] > 0 && sel != 0;
            if ((w || r) && !sv) err_exp[0] = 1'b1;
            if (w && sv) begin
                if (aw < depth_t[sel]) begin
                    lay_m[base_t[sel] + aw] = d;
                    lw_exp |= lbit(sel);
                end else err_exp[1] = 1'b1;
            end
            if (r) begin
                if (sv && ar < depth_t[sel]) cd_exp = lay_m[base_t[sel] + ar];
                else begin
                    cd_exp = '0;
                    if (sv) err_exp[1] = 1'b1;
                end
            end
        end
        chk("idata", idata, live ? img_m[ia] : '0);
        chk("cdata_rd", cdata_rd, cd_exp);
        chk("err", err, err_exp);
        chk("layer_wr", layer_wr, lw_exp);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_idata"}, idata, 0);
        chk({tag, "_cdata"}, cdata_rd, 0);
        chk({tag, "_hrdata"}, h_rdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_lw"}, layer_wr, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic arm_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        err_exp = '0; lw_exp = '0;
        chk("ready_arm", ready, 1);
        busy = 1'b1;
        tick();
        chk("ready_run", ready, 0);
    endtask

    initial begin
        int n, s;
        vecs = 0; errs = 0;
        reset = 1'b0; start = 0; busy = 0; cwr = 0; crd = 0; h_we = 0; h_re = 0;
        iaddr = 0; caddr_wr = 0; caddr_rd = 0; h_addr = 0; cdata_wr = 0; h_wdata = 0;
        csel = 0; h_sel = 0;
        cd_exp = 0; hr_exp = 0; lw_exp = 0; err_exp = 0;
        repeat (3) tick();
        chk_outs_zero("rst");
        reset = 1'b1;
        tick();

        // Preload image and layer pools through the host port.
        for (int a = 0; a < 16; a++) host_wr(0, a, DW'($urandom));
        host_wr(0, 5, 20'h0ABCD);
        for (int b = 1; b <= 5; b++) begin
            for (int a = 0; a < 8; a++) host_wr(b, a, DW'($urandom));
            host_wr(b, depth_t[b] - 1, DW'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            s = $urandom_range(0, 5);
            host_rd("h_pre", s, (s == 0) ? $urandom_range(0, 15) : pick(s) % depth_t[s]);
        end

        // Handshake: busy comes three cycles after ready rises.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ready_hi", ready, 1);
            if (i < 2) tick();
        end
        busy = 1'b1;
        tick();
        chk("ready_lo", ready, 0);

        conv_cyc(1, 0, 0, 0, 0, 0, 0, 5);
        conv_cyc(1, 1, 0, 3, 3, 20'h12345, 0, 5);
        conv_cyc(1, 0, 1, 3, 0, 0, 3, 1);
        conv_cyc(1, 1, 1, 5, 7, 20'hFFFFF, 7, 2);
        conv_cyc(1, 1, 0, 6, 0, 20'h11111, 0, 3);
        conv_cyc(1, 1, 0, 3, 1024, 20'h22222, 0, 4);
        chk("err_0011", err, 4'b0011);

        // Host write while running is dropped and flagged.
        h_sel = 3'd3; h_addr = 0; h_wdata = 20'h33333; h_we = 1'b1;
        tick();
        h_we = 1'b0;
        err_exp[2] = 1'b1;
        chk("err_host", err, err_exp);
        chk("hrd_hold", h_rdata, hr_exp);

        for (int i = 0; i < 300; i++) begin
            s = $urandom_range(0, 7);
            conv_cyc(1, 1'($urandom), 1'($urandom), s, pick(s), DW'($urandom), pick(s),
                     $urandom_range(0, 15));
        end

        busy = 1'b0;
        tick();
        chk("done_hi", done, 1);
        tick();
        chk("done_lo", done, 0);
        host_rd("h_l1k0_3", 3, 3);
        host_rd("h_l1k0_0", 3, 0);
        host_rd("h_l2_7", 5, 7);
        for (int i = 0; i < 10; i++) begin
            s = $urandom_range(1, 5);
            host_rd("h_post", s, pick(s) % depth_t[s]);
        end

        // Arm timeout: busy never comes.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (ready === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        chk("tmo_cycles", n, 1024);
        chk("tmo_err", err, 4'b1000);
        chk("tmo_lw", layer_wr, 0);
        err_exp = 4'b1000; lw_exp = 0;
        host_wr(1, 2, 20'h0F0F0);
        host_rd("h_after_tmo", 1, 2);

        // Asynchronous reset in the middle of a run.
        arm_run();
        conv_cyc(1, 1, 1, 4, 6, 20'h5A5A5, 6, 7);
        reset = 1'b0;
        #1;
        chk_outs_zero("midrst");
        cd_exp = 0; hr_exp = 0; lw_exp = 0; err_exp = 0;
        #2;
        reset = 1'b1;
        conv_cyc(0, 1, 1, 4, 6, 20'h00777, 6, 7);
        chk("ready_after_rst", ready, 0);
        busy = 1'b0;
        tick();
        host_rd("h_after_rst", 4, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
